regfile_sweep: RTL and testbench
================================

# regfile_sweep

Parametrised register file, successor to the fixed 32×32 design, used as the datapath's architectural register store. It keeps two registered read ports and one write port, and adds four things: configurable width and depth, optional write-to-read bypass, an optional hardwired zero register, and a hardware clear sequence after reset. A `ready` flag tells the control unit when the file may be used.

## Interface
- `DATA_W`, default 32: register width in bits.
- `ADDR_W`, default 5: address width; depth `DEPTH = 2**ADDR_W`.
- `BYPASS`, default 1: when 1, a same-cycle write to a register being read is forwarded to the read output.
- `ZERO_REG`, default 1: when 1, register 0 reads as zero and ignores writes.

- `clk`  in  1  clock; everything samples on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `regwrite`  in  1  write enable.
- `rd`  in  ADDR_W  write address.
- `writedata`  in  DATA_W  write data.
- `re`  in  1  read enable; when low, the read outputs hold.
- `rs`  in  ADDR_W  read address, port A.
- `rt`  in  ADDR_W  read address, port B.
- `A_readdat1`  out  DATA_W  registered read data, port A.
- `B_readdat2`  out  DATA_W  registered read data, port B.
- `ready`  out  1  high once the clear sweep has finished.

## Operation
- FSM has two states, CLEAR and RUN.
- `rst`=1 at an edge: state←CLEAR, sweep counter `cnt`←0, `A_readdat1`/`B_readdat2`←0, `ready`←0. No array write happens on that edge.
- CLEAR, `rst`=0: each edge writes mem[`cnt`]←0 and increments `cnt`.
  - When `cnt`==DEPTH−1 the last entry is written and state←RUN, `ready`←1.
  - `regwrite` and `re` are ignored throughout CLEAR; the outputs stay 0.
- RUN:
  - Write: if `regwrite`=1, mem[`rd`]←`writedata`. The write is dropped when `ZERO_REG`=1 and `rd`==0.
  - Read: if `re`=1, each port loads its output register.
    - Zero register: 0 if `ZERO_REG`=1 and the address is 0.
    - Bypass: else `writedata` if `BYPASS`=1, `regwrite`=1 and `rd`==address.
    - Otherwise the pre-write contents of mem[address].
  - Both ports may read the same address; each applies the rule independently.
- `BYPASS`=0: a read of the register being written in the same cycle returns the old value (read-before-write).
- `cnt` is ADDR_W+1 bits wide, so the terminal compare cannot wrap.
- Reset during CLEAR restarts the sweep at entry 0. Reset during RUN re-enters CLEAR and the whole array is re-zeroed.

## Timing
- Read latency is one cycle: the address sampled at edge N appears on the outputs after edge N.
- A write committed at edge N is visible to a non-bypassed read issued at edge N+1.
- After `rst` falls, the first non-reset edge writes entry 0. `ready` rises after the DEPTH-th non-reset edge, which is 32 edges for the defaults.
- The first legal RUN read is issued in the cycle `ready` is first high; its data appears one edge later.
- Reset values: outputs 0, `ready` 0, state CLEAR, `cnt` 0.

## Structure
- Package `regfile_pkg` holds:
  - the state enum `rf_state_t` {CLEAR, RUN};
  - default constants `RF_DATA_W`=32 and `RF_ADDR_W`=5.
- Sub-module `regfile_rdport` is instantiated twice. It contains the zero/bypass/array select mux and the output register with hold, reset and clear behaviour.
- The array is a plain `reg` memory with one synchronous write port. The address mux selects `cnt` in CLEAR and `rd` in RUN.

## Test plan
1. Clear sweep: pulse `rst` for 2 cycles, then release. Require `ready`=0 for exactly 32 edges, then 1. Reading every address then returns 0x00000000.
2. Write then read: in RUN, write 0xDEADBEEF to r5. Next cycle `re`=1, `rs`=5, `rt`=5. One edge later both outputs equal 0xDEADBEEF.
3. Bypass: with r7=0x11111111, in one cycle set `regwrite`=1, `rd`=7, `writedata`=0x22222222, `rs`=7.
   - `BYPASS`=1: `A_readdat1`=0x22222222.
   - `BYPASS`=0: `A_readdat1`=0x11111111 on that read, then 0x22222222 on the next read.
4. Zero register: write 0xFFFFFFFF to r0, then read `rs`=0 while simultaneously writing r0 with bypass enabled. Output is 0 both times.
5. Mid-sweep reset: assert `rst` for 1 cycle at sweep entry 10 after writing garbage to all entries in a prior RUN. `ready` stays 0 for 32 further edges and every entry reads 0 afterwards.
6. Hold and gating: in RUN with `re`=0, change `rs`/`rt`; outputs hold their previous values. In CLEAR, `regwrite`=1 to r3 has no effect: r3 reads 0 after `ready`.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the parametrised register file.
//   rf_state_t : sequencer state (CLEAR sweep, RUN normal operation)
//   RF_DATA_W  : default register width
//   RF_ADDR_W  : default address width (depth = 2**RF_ADDR_W)
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport
//   One registered read port: selects zero / bypassed write data / array
//   data, and holds the result in an output register.
//   Ports:
//     i_clk, i_rst       : clock, synchronous active-high reset
//     i_run              : high when the file is in RUN (loads allowed)
//     i_re               : read enable; output holds when low
//     i_addr             : read address
//     i_mem_data         : pre-write array contents at i_addr
//     i_regwrite, i_rd,
//     i_writedata        : same-cycle write, used for bypass
//     o_data             : registered read data
import regfile_pkg::*;

module regfile_rdport #(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_regwrite,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic [DATA_W-1:0] i_writedata,
  output logic [DATA_W-1:0] o_data
);

  localparam bit USE_BYP  = (BYPASS != 0);
  localparam bit USE_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_sel;

  // Zero register beats bypass, so a write to r0 can never leak out.
  always_comb begin
    w_sel = i_mem_data;
    if (USE_ZERO && (i_addr == '0)) begin
      w_sel = '0;
    end else if (USE_BYP && i_regwrite && (i_rd == i_addr)) begin
      w_sel = i_writedata;
    end
  end

  // Loads only in RUN; during CLEAR the register keeps its reset value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
    end else if (i_run && i_re) begin
      r_data <= w_sel;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/regfile_sweep.sv
// regfile_sweep
//   Parametrised 2-read / 1-write register file with a hardware clear
//   sweep after reset, optional write-to-read bypass and optional
//   hardwired zero register.
//   Ports:
//     clk, rst         : clock, synchronous active-high reset
//     regwrite, rd,
//     writedata        : write port (ignored during CLEAR)
//     re, rs, rt       : read enable and addresses (ignored during CLEAR)
//     A_readdat1,
//     B_readdat2       : registered read data, one cycle latency
//     ready            : high once every entry has been zeroed
//     o_dbg_state      : current sequencer state
//
//   Handshake: ready is a level, not a pulse. The control unit may issue
//   a read or write in any cycle where ready is sampled high at the edge;
//   anything issued while ready is low is dropped. ready stays high until
//   the next rst.
import regfile_pkg::*;

module regfile_sweep #(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] writedata,
  input  logic              re,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] A_readdat1,
  output logic [DATA_W-1:0] B_readdat2,
  output logic              ready,
  output rf_state_t         o_dbg_state
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam bit              USE_ZERO = (ZERO_REG != 0);
  // cnt carries one extra bit so the terminal compare cannot wrap.
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  rf_state_t         r_state;
  rf_state_t         w_state_nxt;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   w_cnt_nxt;
  logic              r_ready;
  logic              w_ready_nxt;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              w_run;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_mem_a;
  logic [DATA_W-1:0] w_mem_b;

  // ---------------- sequencer ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = r_ready;
    case (r_state)
      CLEAR: begin
        w_cnt_nxt = r_cnt + CNT_ONE;
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = RUN;
          w_ready_nxt = 1'b1;
        end
      end
      RUN: begin
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = CLEAR;
      end
    endcase
  end

  assign w_run = (r_state == RUN);

  // ---------------- array write port ----------------
  // CLEAR owns the write port (address = cnt, data = 0); RUN hands it to rd.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = rd;
    w_wdata = writedata;
    if (!w_run) begin
      w_we    = 1'b1;
      w_waddr = r_cnt[ADDR_W-1:0];
      w_wdata = '0;
    end else if (regwrite && !(USE_ZERO && (rd == '0))) begin
      w_we    = 1'b1;
    end
  end

  // No write on a reset edge, so a restarted sweep begins cleanly at 0.
  always_ff @(posedge clk) begin
    if (!rst && w_we) begin
      mem[w_waddr] <= w_wdata;
    end
  end

  // Asynchronous array read gives the pre-write contents for this edge.
  assign w_mem_a = mem[rs];
  assign w_mem_b = mem[rt];

  // ---------------- read ports ----------------
  regfile_rdport #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .BYPASS  (BYPASS),
    .ZERO_REG(ZERO_REG)
  ) u_port_a (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_run      (w_run),
    .i_re       (re),
    .i_addr     (rs),
    .i_mem_data (w_mem_a),
    .i_regwrite (regwrite),
    .i_rd       (rd),
    .i_writedata(writedata),
    .o_data     (A_readdat1)
  );

  regfile_rdport #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .BYPASS  (BYPASS),
    .ZERO_REG(ZERO_REG)
  ) u_port_b (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_run      (w_run),
    .i_re       (re),
    .i_addr     (rt),
    .i_mem_data (w_mem_b),
    .i_regwrite (regwrite),
    .i_rd       (rd),
    .i_writedata(writedata),
    .o_data     (B_readdat2)
  );

  assign ready       = r_ready;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_regfile_sweep.sv
// tb_regfile_sweep
//   Two instances share all inputs: u_dut (BYPASS=1) and u_nb (BYPASS=0),
//   both with ZERO_REG=1. Each scoreboard entry packs the four expected
//   read results {A, B, A_nb, B_nb}.
import regfile_pkg::*;

module tb_regfile_sweep;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int W  = 4 * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          regwrite = 1'b0;
  logic [AW-1:0] rd = '0;
  logic [DW-1:0] writedata = '0;
  logic          re = 1'b0;
  logic [AW-1:0] rs = '0;
  logic [AW-1:0] rt = '0;

  logic [DW-1:0] a_by, b_by, a_nb, b_nb;
  logic          ready_by, ready_nb;
  rf_state_t     st_by, st_nb;

  regfile_sweep #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst(rst), .regwrite(regwrite), .rd(rd), .writedata(writedata),
    .re(re), .rs(rs), .rt(rt), .A_readdat1(a_by), .B_readdat2(b_by),
    .ready(ready_by), .o_dbg_state(st_by)
  );

  regfile_sweep #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0), .ZERO_REG(1)) u_nb (
    .clk(clk), .rst(rst), .regwrite(regwrite), .rd(rd), .writedata(writedata),
    .re(re), .rs(rs), .rt(rt), .A_readdat1(a_nb), .B_readdat2(b_nb),
    .ready(ready_nb), .o_dbg_state(st_nb)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // A read is issued when re and ready are high at the edge; its result
  // is on the outputs just after that edge.
  logic [W-1:0] mon_e;
  always @(posedge clk) begin
    if (re && ready_by && !rst) begin
      #1;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow: read seen with empty expected queue at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_a_byp",   a_by, mon_e[4*DW-1:3*DW]);
        chk("rd_b_byp",   b_by, mon_e[3*DW-1:2*DW]);
        chk("rd_a_nobyp", a_nb, mon_e[2*DW-1:DW]);
        chk("rd_b_nobyp", b_nb, mon_e[DW-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic ren, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic [W-1:0] exp);
    @(negedge clk);
    regwrite  = we;
    rd        = wa;
    writedata = wd;
    re        = ren;
    rs        = ra;
    rt        = rb;
    if (ren) exp_q.push_back(exp);
    @(posedge clk);
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  function automatic logic [W-1:0] e4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                      input logic [DW-1:0] an, input logic [DW-1:0] bn);
    return {a, b, an, bn};
  endfunction

  // Counts non-reset edges until ready is seen; expects DEPTH edges.
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (ready_by) break;
    end
    regwrite = 1'b0;
    re       = 1'b0;
    chk(name, DW'(n), DW'(32));
    chk({name, "_nb"}, DW'(ready_nb), DW'(1));
    chk({name, "_outa"}, a_by, '0);
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(i), AW'(31 - i), '0);
    end
    idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", DW'(ready_by), '0);
    chk("rst_a", a_by, '0);
    chk("rst_b", b_by, '0);
    chk("rst_state", DW'(st_by), DW'(CLEAR));
    @(negedge clk);
    rst = 1'b0;

    // 1. clear sweep
    wait_ready("sweep_ready_edges");
    chk("run_state", DW'(st_by), DW'(RUN));
    read_all_zero();

    // 2. write then read
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, '0);
    drive(1'b0, '0, '0, 1'b1, 5'd5, 5'd5, e4(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF));

    // 3. bypass on both ports, then the committed value
    drive(1'b1, 5'd7, 32'h11111111, 1'b0, '0, '0, '0);
    drive(1'b1, 5'd7, 32'h22222222, 1'b1, 5'd7, 5'd7,
          e4(32'h22222222, 32'h22222222, 32'h11111111, 32'h11111111));
    drive(1'b0, '0, '0, 1'b1, 5'd7, 5'd7, e4(32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222));
    // bypass on port B only, port A reads an unrelated register
    drive(1'b1, 5'd2, 32'h02020202, 1'b0, '0, '0, '0);
    drive(1'b1, 5'd9, 32'h99999999, 1'b1, 5'd2, 5'd9,
          e4(32'h02020202, 32'h99999999, 32'h02020202, 32'h00000000));

    // 4. zero register
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0, '0);
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, '0);
    drive(1'b0, '0, '0, 1'b1, 5'd0, 5'd9, e4('0, 32'h99999999, '0, 32'h99999999));

    // 6a. hold with re low
    drive(1'b0, '0, '0, 1'b1, 5'd5, 5'd7, e4(32'hDEADBEEF, 32'h22222222, 32'hDEADBEEF, 32'h22222222));
    drive(1'b0, '0, '0, 1'b0, 5'd1, 5'd2, '0);
    drive(1'b1, 5'd5, 32'h55555555, 1'b0, 5'd9, 5'd0, '0);
    #1;
    chk("hold_a", a_by, 32'hDEADBEEF);
    chk("hold_b", b_by, 32'h22222222);
    chk("hold_a_nb", a_nb, 32'hDEADBEEF);

    // 5. fill with garbage, then reset mid-sweep at entry 10
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, AW'(i), 32'hA5A50000 | DW'(i), 1'b0, '0, '0, '0);
    end
    idle();
    @(negedge clk);
    rst       = 1'b1;
    regwrite  = 1'b1;
    rd        = 5'd3;
    writedata = 32'h33333333;
    re        = 1'b1;
    rs        = 5'd5;
    rt        = 5'd6;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready", DW'(ready_by), '0);
    chk("midrst_state", DW'(st_by), DW'(CLEAR));
    @(negedge clk);
    rst = 1'b0;
    wait_ready("resweep_ready_edges");
    // 6b. r3 written during CLEAR must read 0; every entry re-zeroed
    read_all_zero();

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", DW'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule
